// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter: shares the single-port main RAM between the Z80 CPU and the IOCTL loader.
// Loader writes are buffered in a small FIFO and drained while the CPU is stalled.
// A pending execute request reaches the CPU as a one-cycle register-set pulse once all loader writes have landed.
module ram_share_arbiter #(
    parameter int ADDR       = 16,
    parameter int DATA       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [ADDR-1:0] cpu_addr,
    input  logic [DATA-1:0] cpu_dout,
    output logic [DATA-1:0] cpu_din,
    output logic            cpu_wait,
    output logic            cpu_regset,
    output logic [ADDR-1:0] cpu_regset_pc,
    input  logic            ldr_download,
    input  logic            ldr_wr,
    input  logic [ADDR-1:0] ldr_addr,
    input  logic [DATA-1:0] ldr_data,
    input  logic            ldr_exec,
    input  logic [ADDR-1:0] ldr_exec_addr,
    output logic [DATA-1:0] ldr_din,
    output logic            ldr_rvalid,
    output logic            ldr_wait,
    output logic [ADDR-1:0] ram_addr,
    output logic            ram_we,
    output logic [DATA-1:0] ram_din,
    input  logic [DATA-1:0] ram_dout,
    output logic            ovf
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_CPU, S_LOADER, S_DRAIN, S_EXEC} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            exec_pend_q, exec_pend_d;
    logic [ADDR-1:0] exec_addr_q, exec_addr_d;
    logic            cpu_regset_q, cpu_regset_d;
    logic [ADDR-1:0] cpu_regset_pc_q, cpu_regset_pc_d;
    logic            ldr_rvalid_q, ldr_rvalid_d;
    logic            ovf_q, ovf_d;
    logic [ADDR-1:0] fifo_addr_mem [FIFO_DEPTH];
    logic [DATA-1:0] fifo_data_mem [FIFO_DEPTH];
    logic            full, empty, draining, pop, push;

    assign full     = count_q == FULL_CNT;
    assign empty    = count_q == '0;
    assign draining = state_q == S_LOADER || state_q == S_DRAIN;
    assign pop      = draining && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push     = ldr_wr && (!full || pop);

    assign cpu_din       = ram_dout;
    assign ldr_din       = ram_dout;
    assign cpu_wait      = state_q != S_CPU;
    assign ldr_wait      = full;
    assign cpu_regset    = cpu_regset_q;
    assign cpu_regset_pc = cpu_regset_pc_q;
    assign ldr_rvalid    = ldr_rvalid_q;
    assign ovf           = ovf_q;

    // RAM port mux: CPU owns it in S_CPU, otherwise the FIFO head or the loader read address.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_dout;
        ram_we   = 1'b0;
        if (state_q == S_CPU) begin
            ram_we = cpu_req && cpu_we;
        end else if (pop) begin
            ram_addr = fifo_addr_mem[rd_ptr_q];
            ram_din  = fifo_data_mem[rd_ptr_q];
            ram_we   = 1'b1;
        end else if (draining) begin
            ram_addr = ldr_addr;
        end
        if (!reset_n) ram_we = 1'b0;
    end

    // Next-state logic for the FIFO bookkeeping, execute request and ownership FSM.
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        exec_pend_d = ldr_exec || (exec_pend_q && state_q != S_EXEC);
        exec_addr_d = ldr_exec ? ldr_exec_addr : exec_addr_q;
        state_d     = S_CPU;
        unique case (state_q)
            S_CPU:    state_d = ldr_download ? S_LOADER : (exec_pend_d && count_d == '0) ? S_EXEC : S_CPU;
            S_LOADER: state_d = ldr_download ? S_LOADER : S_DRAIN;
            S_DRAIN:  state_d = ldr_download ? S_LOADER : (count_d != '0) ? S_DRAIN : exec_pend_d ? S_EXEC : S_CPU;
            default:  state_d = S_CPU;
        endcase
        cpu_regset_d    = state_d == S_EXEC;
        cpu_regset_pc_d = (state_d == S_EXEC) ? exec_addr_d : cpu_regset_pc_q;
        ldr_rvalid_d    = state_q == S_LOADER && empty;
        ovf_d           = ovf_q || (ldr_wr && !push);
    end

    // State and registered outputs; reset discards any queued loader writes.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= S_CPU;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            exec_pend_q     <= 1'b0;
            exec_addr_q     <= '0;
            cpu_regset_q    <= 1'b0;
            cpu_regset_pc_q <= '0;
            ldr_rvalid_q    <= 1'b0;
            ovf_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            exec_pend_q     <= exec_pend_d;
            exec_addr_q     <= exec_addr_d;
            cpu_regset_q    <= cpu_regset_d;
            cpu_regset_pc_q <= cpu_regset_pc_d;
            ldr_rvalid_q    <= ldr_rvalid_d;
            ovf_q           <= ovf_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_mem[wr_ptr_q] <= ldr_addr;
            fifo_data_mem[wr_ptr_q] <= ldr_data;
        end
    end
endmodule
